// File: rtl/snake_pkg.sv
// Shared definitions for the snake board writer/reader pair.
//
// Contents:
//   SNAKE_COORD_W : default bits per board coordinate (16x16 grid).
//   CELL_*        : 2-bit cell codes stored in the board RAM.
//   seg_t         : 8-bit packed segment location {y[7:4], x[3:0]}.
//   make_seg      : builds a seg_t from separate x/y coordinates.
package snake_pkg;

    localparam int SNAKE_COORD_W = 4;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_FOOD  = 2'b01;
    localparam logic [1:0] CELL_SNAKE = 2'b10;
    localparam logic [1:0] CELL_WALL  = 2'b11;

    typedef struct packed {
        logic [3:0] y;
        logic [3:0] x;
    } seg_t;

    function automatic seg_t make_seg(input logic [3:0] x, input logic [3:0] y);
        seg_t s;
        s.x = x;
        s.y = y;
        return s;
    endfunction

endpackage

// File: rtl/board_rd_tag_pipe.sv
// Tag shift register that travels alongside the board RAM read pipeline.
// Each cycle one {valid, x, y} tag enters; it leaves DEPTH cycles later,
// lined up with the RAM data for that address.
//
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset (clears all tags).
//   in_valid_i       : tag entering this cycle carries a real scan read.
//   in_x_i, in_y_i   : address of that read.
//   out_valid_o      : oldest tag is valid (its data is on the RAM output now).
//   out_x_o, out_y_o : address of the oldest tag.
//   pending_o        : some valid tag is still in flight behind the oldest one.
module board_rd_tag_pipe #(
    parameter int COORD_W = 4,
    parameter int DEPTH   = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               in_valid_i,
    input  logic [COORD_W-1:0] in_x_i,
    input  logic [COORD_W-1:0] in_y_i,
    output logic               out_valid_o,
    output logic [COORD_W-1:0] out_x_o,
    output logic [COORD_W-1:0] out_y_o,
    output logic               pending_o
);

    typedef struct packed {
        logic               v;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } tag_t;

    tag_t stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= '{v: in_valid_i, x: in_x_i, y: in_y_i};
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid_o = stage_q[DEPTH-1].v;
    assign out_x_o     = stage_q[DEPTH-1].x;
    assign out_y_o     = stage_q[DEPTH-1].y;

    // Only the stages behind the output count: the output tag is consumed
    // in the same cycle it is observed.
    always_comb begin
        pending_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending_o = pending_o | stage_q[i].v;
        end
    end

endmodule

// File: rtl/snake_board_reader.sv
// Read-side access to the 16x16 snake board RAM.
// Serves single-cell queries and a full raster scan that reports the first
// food cell (raster order) and the number of snake cells.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset.
//   query_valid/query_x/_y     : single-cell query request (taken in IDLE only).
//   start_scan                 : full-board scan request (taken in IDLE only;
//                                loses to query_valid in the same cycle).
//   x_loc, y_loc, rd_en        : registered RAM read address / enable.
//   data_in                    : RAM data, valid RD_LATENCY cycles after the
//                                address/rd_en edge.
//   busy                       : high whenever not IDLE.
//   query_done, query_data     : one-cycle done pulse; cell code held until
//                                the next query completes.
//   scan_done                  : one-cycle done pulse for the scan.
//   food_found, food_x, food_y : first food cell of the last scan.
//   snake_count                : snake cells in the last scan (saturating).
//
// Handshake: a request is a single-cycle level sampled on the clock edge
// while busy=0; anything presented while busy=1 is dropped, never queued.
module snake_board_reader
    import snake_pkg::*;
#(
    parameter int COORD_W    = SNAKE_COORD_W,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 query_valid,
    input  logic [COORD_W-1:0]   query_x,
    input  logic [COORD_W-1:0]   query_y,
    input  logic                 start_scan,
    output logic [COORD_W-1:0]   x_loc,
    output logic [COORD_W-1:0]   y_loc,
    output logic                 rd_en,
    input  logic [1:0]           data_in,
    output logic                 busy,
    output logic                 query_done,
    output logic [1:0]           query_data,
    output logic                 scan_done,
    output logic                 food_found,
    output logic [COORD_W-1:0]   food_x,
    output logic [COORD_W-1:0]   food_y,
    output logic [2*COORD_W:0]   snake_count
);

    localparam int AW = 2 * COORD_W;
    localparam int CW = 2 * COORD_W + 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_Q_ISSUE = 3'd1;
    localparam logic [2:0] ST_Q_WAIT  = 3'd2;
    localparam logic [2:0] ST_SCAN    = 3'd3;
    localparam logic [2:0] ST_S_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE_Q  = 3'd5;
    localparam logic [2:0] ST_DONE_S  = 3'd6;

    // Q_WAIT lasts RD_LATENCY cycles; capture happens on its last one.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    logic [2:0]         state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               rd_en_q, rd_en_d;
    logic [1:0]         wait_cnt_q, wait_cnt_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [1:0]         query_data_q, query_data_d;
    logic               food_found_q, food_found_d;
    logic [COORD_W-1:0] food_x_q, food_x_d;
    logic [COORD_W-1:0] food_y_q, food_y_d;
    logic [CW-1:0]      snake_count_q, snake_count_d;

    logic               tag_valid;
    logic [COORD_W-1:0] tag_x;
    logic [COORD_W-1:0] tag_y;
    logic               tag_pending;

    // Only scan reads are tagged; query reads share the RAM port but are
    // handled by the Q_WAIT counter instead.
    board_rd_tag_pipe #(
        .COORD_W (COORD_W),
        .DEPTH   (RD_LATENCY)
    ) u_tag_pipe (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (rd_en_q && (state_q == ST_SCAN)),
        .in_x_i      (x_q),
        .in_y_i      (y_q),
        .out_valid_o (tag_valid),
        .out_x_o     (tag_x),
        .out_y_o     (tag_y),
        .pending_o   (tag_pending)
    );

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        rd_en_d       = rd_en_q;
        wait_cnt_d    = wait_cnt_q;
        addr_d        = addr_q;
        query_data_d  = query_data_q;
        food_found_d  = food_found_q;
        food_x_d      = food_x_q;
        food_y_d      = food_y_q;
        snake_count_d = snake_count_q;

        // Scan result accumulation: each returning tag pairs data_in with
        // the address it was read from.
        if (tag_valid) begin
            if (data_in == CELL_SNAKE && snake_count_q != {CW{1'b1}}) begin
                snake_count_d = snake_count_q + 1'b1;
            end
            if (data_in == CELL_FOOD && !food_found_q) begin
                food_found_d = 1'b1;
                food_x_d     = tag_x;
                food_y_d     = tag_y;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (query_valid) begin
                    x_d     = query_x;
                    y_d     = query_y;
                    rd_en_d = 1'b1;
                    state_d = ST_Q_ISSUE;
                end else if (start_scan) begin
                    food_found_d  = 1'b0;
                    food_x_d      = '0;
                    food_y_d      = '0;
                    snake_count_d = '0;
                    // Address 0 goes out on this edge, so the counter
                    // already points at the next address to issue.
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = {{(AW-1){1'b0}}, 1'b1};
                    rd_en_d = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_Q_ISSUE: begin
                rd_en_d    = 1'b0;
                wait_cnt_d = '0;
                state_d    = ST_Q_WAIT;
            end
            ST_Q_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    query_data_d = data_in;
                    state_d      = ST_DONE_Q;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_SCAN: begin
                // Counter wrapped to zero: the last address is on the bus now.
                if (addr_q == '0) begin
                    rd_en_d = 1'b0;
                    state_d = ST_S_DRAIN;
                end else begin
                    y_d    = addr_q[AW-1:COORD_W];
                    x_d    = addr_q[COORD_W-1:0];
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_S_DRAIN: begin
                if (!tag_pending) begin
                    state_d = ST_DONE_S;
                end
            end
            ST_DONE_Q: state_d = ST_IDLE;
            ST_DONE_S: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            rd_en_q       <= 1'b0;
            wait_cnt_q    <= '0;
            addr_q        <= '0;
            query_data_q  <= '0;
            food_found_q  <= 1'b0;
            food_x_q      <= '0;
            food_y_q      <= '0;
            snake_count_q <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rd_en_q       <= rd_en_d;
            wait_cnt_q    <= wait_cnt_d;
            addr_q        <= addr_d;
            query_data_q  <= query_data_d;
            food_found_q  <= food_found_d;
            food_x_q      <= food_x_d;
            food_y_q      <= food_y_d;
            snake_count_q <= snake_count_d;
        end
    end

    assign x_loc       = x_q;
    assign y_loc       = y_q;
    assign rd_en       = rd_en_q;
    assign busy        = (state_q != ST_IDLE);
    assign query_done  = (state_q == ST_DONE_Q);
    assign scan_done   = (state_q == ST_DONE_S);
    assign query_data  = query_data_q;
    assign food_found  = food_found_q;
    assign food_x      = food_x_q;
    assign food_y      = food_y_q;
    assign snake_count = snake_count_q;

endmodule

// File: doc/snake_board_reader.md
Name: snake_board_reader

Overview:
- Read-side counterpart of the snake segment writer; reads back the 16x16 board RAM that the writer fills.
- Serves single-cell queries, e.g. a head-collision check by the game FSM.
- Also performs a full raster scan reporting the first food cell and the number of snake cells.
- Sits between the game control FSM and the board RAM read port; uses the same x_loc/y_loc addressing and 2-bit cell codes as the writer.

Parameters:
- COORD_W, 4, bits per coordinate; grid is 2^COORD_W x 2^COORD_W.
- RD_LATENCY, 1, board RAM read latency in cycles, valid range 1..3.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- query_valid  in  1  single-cell query request; sampled only in IDLE.
- query_x  in  COORD_W  query column.
- query_y  in  COORD_W  query row.
- start_scan  in  1  full-board scan request; sampled only in IDLE.
- x_loc  out  COORD_W  RAM read column address (registered).
- y_loc  out  COORD_W  RAM read row address (registered).
- rd_en  out  1  RAM read enable (registered).
- data_in  in  2  RAM read data, valid RD_LATENCY cycles after the address/rd_en edge.
- busy  out  1  high in any state other than IDLE.
- query_done  out  1  one-cycle pulse; query_data valid.
- query_data  out  2  cell code of the queried cell; held until the next query completes.
- scan_done  out  1  one-cycle pulse; scan results valid.
- food_found  out  1  at least one food cell seen in the last scan.
- food_x  out  COORD_W  column of the first food cell in raster order.
- food_y  out  COORD_W  row of the first food cell in raster order.
- snake_count  out  2*COORD_W+1  count of snake cells (0..256 at default).

Behaviour:
- Cell codes: 00 empty, 01 food, 10 snake, 11 wall.
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including x_loc, y_loc, query_data, food_*, snake_count.
  - The scan counter and the read-tag pipeline are cleared.
- States: IDLE, Q_ISSUE, Q_WAIT, SCAN, S_DRAIN, DONE_Q, DONE_S.
- Start decision in IDLE:
  - query_valid wins over start_scan when both are high in the same cycle; start_scan is dropped and must be re-asserted.
  - Requests presented while busy=1 are ignored (not queued).
- Query sequence:
  - Accept edge: x_loc<=query_x, y_loc<=query_y, rd_en<=1, go to Q_ISSUE.
  - Next edge: rd_en<=0, go to Q_WAIT.
  - Q_WAIT counts so that data_in is captured exactly RD_LATENCY cycles after the issue edge: query_data<=data_in, then DONE_Q.
  - DONE_Q: query_done=1 for one cycle, then IDLE.
  - Latency at RD_LATENCY=1: query_done is high in the 3rd cycle after the accept cycle.
- Scan sequence:
  - Accept edge: clear food_found, food_x/y and snake_count; address counter A=0; rd_en<=1.
  - In SCAN, one address is issued per cycle: y_loc=A[2*COORD_W-1:COORD_W], x_loc=A[COORD_W-1:0], A increments.
  - A (2*COORD_W bits) wraps after all-ones; the wrap edge moves to S_DRAIN with rd_en<=0.
  - A tag shift register of depth RD_LATENCY carries {valid, address} alongside the RAM, so each data_in is paired with its address.
  - On each valid tag:
    - data_in==10: snake_count++.
    - data_in==01 and food_found==0: latch food_x/food_y, set food_found. Later food cells are ignored.
  - S_DRAIN waits until the tag pipeline is empty, then goes to DONE_S.
  - DONE_S: scan_done=1 for one cycle, then IDLE.
  - Total cycles from accept to scan_done = 256 + RD_LATENCY + 1.
- snake_count saturates at its maximum and never wraps; 256 is reachable only on a full-snake board.
- Reset mid-query or mid-scan: immediate return to IDLE with no done pulse; partial results are cleared.
- Results (query_data, food_*, snake_count) stay stable outside their own operation.

Decomposition:
- Shared package snake_pkg:
  - cell-code constants CELL_EMPTY, CELL_FOOD, CELL_SNAKE, CELL_WALL.
  - COORD_W default.
  - 8-bit packed segment layout {y[7:4], x[3:0]}.
  - The writer is updated to take data_out from the same package.
- One sub-module, board_rd_tag_pipe: parameterised RD_LATENCY-deep shift register of {valid, x, y}, used by the scan path.

Test Plan:
- Query (5,3) with cell (5,3)=10, RD_LATENCY=1 -> rd_en high one cycle with x_loc=5, y_loc=3; query_done pulses 3 cycles after accept; query_data=10.
- Scan a board with food at (7,2) and (1,9) plus snake cells (4,4),(5,4),(6,4) -> food_found=1, food_x=7, food_y=2, snake_count=3; scan_done pulses at cycle 258 after accept.
- Scan an all-empty board -> food_found=0, snake_count=0, scan_done asserted exactly once.
- query_valid and start_scan asserted together in IDLE -> only the query runs; no scan_done; a query_valid during the following busy window is ignored.
- Reset asserted at scan address 100 -> next cycle busy=0, rd_en=0, snake_count=0, no scan_done; a fresh scan then completes correctly.
- RD_LATENCY=3 with the RAM model delayed to match -> cell (15,15)=01 reported as food_x=15, food_y=15 (last address paired correctly); query latency is 5 cycles.
